// File: rtl/router_fsm_if.sv
// Handshake and control bundle between the 1x3 router datapath and its packet-sequencing FSM.
// The slave modport is the FSM view. The master modport is the source/synchronizer view.
interface router_fsm_if;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic       fifo_empty_0;
    logic       fifo_empty_1;
    logic       fifo_empty_2;
    logic       soft_reset_0;
    logic       soft_reset_1;
    logic       soft_reset_2;
    logic       parity_done;
    logic       low_pkt_valid;

    logic       detect_add;
    logic       lfd_state;
    logic       ld_state;
    logic       laf_state;
    logic       full_state;
    logic       write_enb_reg;
    logic       rst_int_reg;
    logic       busy;

    modport slave (
        input  pkt_valid, data_in, fifo_full,
        input  fifo_empty_0, fifo_empty_1, fifo_empty_2,
        input  soft_reset_0, soft_reset_1, soft_reset_2,
        input  parity_done, low_pkt_valid,
        output detect_add, lfd_state, ld_state, laf_state, full_state,
        output write_enb_reg, rst_int_reg, busy
    );

    modport master (
        output pkt_valid, data_in, fifo_full,
        output fifo_empty_0, fifo_empty_1, fifo_empty_2,
        output soft_reset_0, soft_reset_1, soft_reset_2,
        output parity_done, low_pkt_valid,
        input  detect_add, lfd_state, ld_state, laf_state, full_state,
        input  write_enb_reg, rst_int_reg, busy
    );
endinterface

// File: rtl/router_fsm.sv
// Packet-sequencing controller for the 1x3 router: header decode, payload, full stall and parity phases.
// Define ROUTER_FSM_PARITY_CHK_EN to add the CHECK_PARITY_ERROR phase and the rst_int_reg pulse.
module router_fsm (
    input  logic        clock,
    input  logic        resetn,
    router_fsm_if.slave bus
);

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        FIFO_FULL_STATE    = 3'd3,
        LOAD_AFTER_FULL    = 3'd4,
        LOAD_PARITY        = 3'd5,
        CHECK_PARITY_ERROR = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic [1:0] r_addr_q;
    logic       w_addr_empty;
    logic       w_addr_soft_reset;

    logic       r_detect_add;
    logic       r_lfd_state;
    logic       r_ld_state;
    logic       r_laf_state;
    logic       r_full_state;
    logic       r_write_enb_reg;
    logic       r_rst_int_reg;
    logic       r_busy;

    logic       w_detect_add;
    logic       w_lfd_state;
    logic       w_ld_state;
    logic       w_laf_state;
    logic       w_full_state;
    logic       w_write_enb_reg;
    logic       w_rst_int_reg;
    logic       w_busy;

    always_comb begin
        w_addr_empty      = 1'b0;
        w_addr_soft_reset = 1'b0;
        case (r_addr_q)
            2'd0: begin
                w_addr_empty      = bus.fifo_empty_0;
                w_addr_soft_reset = bus.soft_reset_0;
            end
            2'd1: begin
                w_addr_empty      = bus.fifo_empty_1;
                w_addr_soft_reset = bus.soft_reset_1;
            end
            2'd2: begin
                w_addr_empty      = bus.fifo_empty_2;
                w_addr_soft_reset = bus.soft_reset_2;
            end
            default: begin
                w_addr_empty      = 1'b0;
                w_addr_soft_reset = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            DECODE_ADDRESS: begin
                if (bus.pkt_valid) begin
                    case (bus.data_in)
                        2'd0: w_next_state = bus.fifo_empty_0 ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                        2'd1: w_next_state = bus.fifo_empty_1 ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                        2'd2: w_next_state = bus.fifo_empty_2 ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                        default: w_next_state = DECODE_ADDRESS;
                    endcase
                end
            end
            WAIT_TILL_EMPTY: begin
                if (w_addr_empty) begin
                    w_next_state = LOAD_FIRST_DATA;
                end
            end
            LOAD_FIRST_DATA: begin
                w_next_state = LOAD_DATA;
            end
            LOAD_DATA: begin
                if (bus.fifo_full) begin
                    w_next_state = FIFO_FULL_STATE;
                end else if (!bus.pkt_valid) begin
                    w_next_state = LOAD_PARITY;
                end
            end
            FIFO_FULL_STATE: begin
                if (!bus.fifo_full) begin
                    w_next_state = LOAD_AFTER_FULL;
                end
            end
            LOAD_AFTER_FULL: begin
                if (bus.parity_done) begin
                    w_next_state = DECODE_ADDRESS;
                end else if (bus.low_pkt_valid) begin
                    w_next_state = LOAD_PARITY;
                end else begin
                    w_next_state = LOAD_DATA;
                end
            end
            LOAD_PARITY: begin
`ifdef ROUTER_FSM_PARITY_CHK_EN
                w_next_state = CHECK_PARITY_ERROR;
`else
                w_next_state = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
`endif
            end
            CHECK_PARITY_ERROR: begin
`ifdef ROUTER_FSM_PARITY_CHK_EN
                w_next_state = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
`else
                w_next_state = DECODE_ADDRESS;
`endif
            end
            default: begin
                w_next_state = DECODE_ADDRESS;
            end
        endcase

        // A timeout on the FIFO this packet targets abandons the packet from any active phase.
        if ((r_state != DECODE_ADDRESS) && w_addr_soft_reset) begin
            w_next_state = DECODE_ADDRESS;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= DECODE_ADDRESS;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_addr_q <= 2'd0;
        end else if ((r_state == DECODE_ADDRESS) && bus.pkt_valid && (bus.data_in != 2'd3)) begin
            r_addr_q <= bus.data_in;
        end
    end

    // Outputs are decoded from the next state and registered, so each strobe comes
    // straight from a flop. This gives the Moore timing of the state register without
    // decode glitches.
    always_comb begin
        w_detect_add    = (w_next_state == DECODE_ADDRESS);
        w_lfd_state     = (w_next_state == LOAD_FIRST_DATA);
        w_ld_state      = (w_next_state == LOAD_DATA);
        w_laf_state     = (w_next_state == LOAD_AFTER_FULL);
        w_full_state    = (w_next_state == FIFO_FULL_STATE);
        w_write_enb_reg = (w_next_state == LOAD_DATA) ||
                          (w_next_state == LOAD_PARITY) ||
                          (w_next_state == LOAD_AFTER_FULL);
`ifdef ROUTER_FSM_PARITY_CHK_EN
        w_rst_int_reg   = (w_next_state == CHECK_PARITY_ERROR);
`else
        w_rst_int_reg   = 1'b0;
`endif
        w_busy          = !((w_next_state == DECODE_ADDRESS) || (w_next_state == LOAD_DATA));
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_detect_add    <= 1'b1;
            r_lfd_state     <= 1'b0;
            r_ld_state      <= 1'b0;
            r_laf_state     <= 1'b0;
            r_full_state    <= 1'b0;
            r_write_enb_reg <= 1'b0;
            r_rst_int_reg   <= 1'b0;
            r_busy          <= 1'b0;
        end else begin
            r_detect_add    <= w_detect_add;
            r_lfd_state     <= w_lfd_state;
            r_ld_state      <= w_ld_state;
            r_laf_state     <= w_laf_state;
            r_full_state    <= w_full_state;
            r_write_enb_reg <= w_write_enb_reg;
            r_rst_int_reg   <= w_rst_int_reg;
            r_busy          <= w_busy;
        end
    end

    assign bus.detect_add    = r_detect_add;
    assign bus.lfd_state     = r_lfd_state;
    assign bus.ld_state      = r_ld_state;
    assign bus.laf_state     = r_laf_state;
    assign bus.full_state    = r_full_state;
    assign bus.write_enb_reg = r_write_enb_reg;
    assign bus.rst_int_reg   = r_rst_int_reg;
    assign bus.busy          = r_busy;

endmodule

// File: tb/tb_router_fsm.sv
// Self-checking bench for router_fsm: expected phases are queued when stimulus is driven
// and compared against the observed strobes one cycle later.
module tb_router_fsm;

    typedef enum int {T_DEC, T_LFD, T_LD, T_FULL, T_LAF, T_LP, T_CPE, T_WAIT} tstate_t;

    typedef struct {
        logic       pv;
        logic [1:0] din;
        logic       full;
        logic [2:0] empty;
        logic [2:0] srst;
        logic       pdone;
        logic       lpv;
        tstate_t    st;
    } step_t;

`ifdef ROUTER_FSM_PARITY_CHK_EN
    localparam tstate_t AFTER_LP  = T_CPE;
    localparam int      RST_PULSE = 1;
`else
    localparam tstate_t AFTER_LP  = T_DEC;
    localparam int      RST_PULSE = 0;
`endif

    logic    clock;
    logic    resetn;
    int      checks;
    int      failures;
    tstate_t expQ[$];

    router_fsm_if bus();

    router_fsm dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Strobe vector: {detect_add, lfd, ld, laf, full, write_enb, rst_int, busy}
    function automatic logic [7:0] outVec();
        return {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state,
                bus.full_state, bus.write_enb_reg, bus.rst_int_reg, bus.busy};
    endfunction

    function automatic logic [7:0] stateVec(input tstate_t s);
        case (s)
            T_DEC:   return 8'b1000_0000;
            T_LFD:   return 8'b0100_0001;
            T_LD:    return 8'b0010_0100;
            T_FULL:  return 8'b0000_1001;
            T_LAF:   return 8'b0001_0101;
            T_LP:    return 8'b0000_0101;
            T_CPE:   return 8'b0000_0011;
            T_WAIT:  return 8'b0000_0001;
            default: return 8'bxxxx_xxxx;
        endcase
    endfunction

    function automatic step_t mk(input logic pv, input logic [1:0] din, input logic full,
                                 input logic [2:0] empty, input logic [2:0] srst,
                                 input logic pdone, input logic lpv, input tstate_t st);
        step_t s;
        s.pv = pv; s.din = din; s.full = full; s.empty = empty;
        s.srst = srst; s.pdone = pdone; s.lpv = lpv; s.st = st;
        return s;
    endfunction

    task automatic applyStimulus(input step_t s);
        bus.pkt_valid     = s.pv;
        bus.data_in       = s.din;
        bus.fifo_full     = s.full;
        bus.fifo_empty_0  = s.empty[0];
        bus.fifo_empty_1  = s.empty[1];
        bus.fifo_empty_2  = s.empty[2];
        bus.soft_reset_0  = s.srst[0];
        bus.soft_reset_1  = s.srst[1];
        bus.soft_reset_2  = s.srst[2];
        bus.parity_done   = s.pdone;
        bus.low_pkt_valid = s.lpv;
        expQ.push_back(s.st);
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        step_t   steps[$];
        tstate_t e;
        resetn = 1'b0;
        applyStimulus(mk(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, T_DEC));
        e = expQ.pop_front();
        checks++;
        if (outVec() !== stateVec(e)) begin
            failures++;
            $display("[TB] FAIL reset_init got %b want %b", outVec(), stateVec(e));
        end
        resetn = 1'b1;
        steps.push_back(mk(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, T_DEC));
        steps.push_back(mk(1, 2'd1, 0, 3'b111, 3'b000, 0, 0, T_LFD));
        steps.push_back(mk(1, 2'd1, 0, 3'b111, 3'b000, 0, 0, T_LD));
        steps.push_back(mk(1, 2'd1, 0, 3'b111, 3'b000, 0, 0, T_LD));
        foreach (steps[i]) begin
            applyStimulus(steps[i]);
            e = expQ.pop_front();
            checks++;
            if (outVec() !== stateVec(e)) begin
                failures++;
                $display("[TB] FAIL reset_pre%0d got %b want %b", i, outVec(), stateVec(e));
            end
        end
        #2 resetn = 1'b0;
        #1;
        checks++;
        if (outVec() !== stateVec(T_DEC)) begin
            failures++;
            $display("[TB] FAIL reset_async got %b want %b", outVec(), stateVec(T_DEC));
        end
        checks++;
        if (dut.r_addr_q !== 2'd0) begin
            failures++;
            $display("[TB] FAIL reset_addr got %0d want 0", dut.r_addr_q);
        end
        @(negedge clock);
        resetn = 1'b1;
        steps.delete();
        steps.push_back(mk(0, 2'd1, 0, 3'b111, 3'b000, 0, 0, T_DEC));
        steps.push_back(mk(0, 2'd1, 0, 3'b111, 3'b000, 0, 0, T_DEC));
        foreach (steps[i]) begin
            applyStimulus(steps[i]);
            e = expQ.pop_front();
            checks++;
            if (outVec() !== stateVec(e)) begin
                failures++;
                $display("[TB] FAIL reset_post%0d got %b want %b", i, outVec(), stateVec(e));
            end
        end
    endtask

    task automatic test_normal_packet();
        step_t   steps[$];
        tstate_t e;
        int      wenCount = 0;
        int      rstCount = 0;
        steps.push_back(mk(1, 2'd1, 0, 3'b111, 3'b000, 0, 0, T_LFD));
        steps.push_back(mk(1, 2'd1, 0, 3'b111, 3'b000, 0, 0, T_LD));
        steps.push_back(mk(1, 2'd1, 0, 3'b111, 3'b000, 0, 0, T_LD));
        steps.push_back(mk(1, 2'd1, 0, 3'b111, 3'b000, 0, 0, T_LD));
        steps.push_back(mk(0, 2'd1, 0, 3'b111, 3'b000, 0, 0, T_LP));
        steps.push_back(mk(0, 2'd1, 0, 3'b111, 3'b000, 0, 0, AFTER_LP));
        steps.push_back(mk(0, 2'd1, 0, 3'b111, 3'b000, 0, 0, T_DEC));
        foreach (steps[i]) begin
            applyStimulus(steps[i]);
            e = expQ.pop_front();
            wenCount += int'(bus.write_enb_reg);
            rstCount += int'(bus.rst_int_reg);
            checks++;
            if (outVec() !== stateVec(e)) begin
                failures++;
                $display("[TB] FAIL normal_step%0d got %b want %b", i, outVec(), stateVec(e));
            end
        end
        checks++;
        if (wenCount != 4) begin
            failures++;
            $display("[TB] FAIL normal_wen_cycles got %0d want 4", wenCount);
        end
        checks++;
        if (rstCount != RST_PULSE) begin
            failures++;
            $display("[TB] FAIL normal_rst_int_cycles got %0d want %0d", rstCount, RST_PULSE);
        end
    endtask

    task automatic test_busy_target();
        step_t   steps[$];
        tstate_t e;
        int      busyCount = 0;
        steps.push_back(mk(1, 2'd2, 0, 3'b011, 3'b000, 0, 0, T_WAIT));
        for (int k = 0; k < 5; k++) begin
            steps.push_back(mk(1, 2'd2, 0, 3'b011, 3'b000, 0, 0, T_WAIT));
        end
        steps.push_back(mk(1, 2'd2, 0, 3'b111, 3'b000, 0, 0, T_LFD));
        steps.push_back(mk(1, 2'd2, 0, 3'b111, 3'b000, 0, 0, T_LD));
        steps.push_back(mk(0, 2'd2, 0, 3'b111, 3'b000, 0, 0, T_LP));
        steps.push_back(mk(0, 2'd2, 0, 3'b111, 3'b000, 0, 0, AFTER_LP));
        steps.push_back(mk(0, 2'd2, 0, 3'b111, 3'b000, 0, 0, T_DEC));
        foreach (steps[i]) begin
            applyStimulus(steps[i]);
            e = expQ.pop_front();
            if (i < 6) busyCount += int'(bus.busy);
            checks++;
            if (outVec() !== stateVec(e)) begin
                failures++;
                $display("[TB] FAIL busy_step%0d got %b want %b", i, outVec(), stateVec(e));
            end
        end
        checks++;
        if (busyCount != 6) begin
            failures++;
            $display("[TB] FAIL busy_wait_cycles got %0d want 6", busyCount);
        end
    endtask

    task automatic test_invalid_address();
        step_t   steps[$];
        tstate_t e;
        for (int k = 0; k < 3; k++) begin
            steps.push_back(mk(1, 2'd3, 0, 3'b111, 3'b000, 0, 0, T_DEC));
        end
        foreach (steps[i]) begin
            applyStimulus(steps[i]);
            e = expQ.pop_front();
            checks++;
            if (outVec() !== stateVec(e)) begin
                failures++;
                $display("[TB] FAIL invalid_step%0d got %b want %b", i, outVec(), stateVec(e));
            end
        end
        checks++;
        if (dut.r_addr_q !== 2'd2) begin
            failures++;
            $display("[TB] FAIL invalid_addr_hold got %0d want 2", dut.r_addr_q);
        end
    endtask

    task automatic test_full_stall();
        step_t   steps[$];
        tstate_t e;
        int      fullCount = 0;
        steps.push_back(mk(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, T_LFD));
        steps.push_back(mk(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, T_LD));
        steps.push_back(mk(0, 2'd0, 1, 3'b111, 3'b000, 0, 1, T_FULL));
        for (int k = 0; k < 3; k++) begin
            steps.push_back(mk(0, 2'd0, 1, 3'b111, 3'b000, 0, 1, T_FULL));
        end
        steps.push_back(mk(0, 2'd0, 0, 3'b111, 3'b000, 0, 1, T_LAF));
        steps.push_back(mk(0, 2'd0, 0, 3'b111, 3'b000, 0, 1, T_LP));
        steps.push_back(mk(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, AFTER_LP));
        steps.push_back(mk(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, T_DEC));
        foreach (steps[i]) begin
            applyStimulus(steps[i]);
            e = expQ.pop_front();
            fullCount += int'(bus.full_state);
            checks++;
            if (outVec() !== stateVec(e)) begin
                failures++;
                $display("[TB] FAIL full_step%0d got %b want %b", i, outVec(), stateVec(e));
            end
        end
        checks++;
        if (fullCount != 4) begin
            failures++;
            $display("[TB] FAIL full_stall_cycles got %0d want 4", fullCount);
        end
    endtask

    task automatic test_soft_reset();
        step_t   steps[$];
        tstate_t e;
        steps.push_back(mk(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, T_LFD));
        steps.push_back(mk(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, T_LD));
        steps.push_back(mk(1, 2'd0, 1, 3'b111, 3'b000, 0, 0, T_FULL));
        steps.push_back(mk(1, 2'd0, 1, 3'b111, 3'b010, 0, 0, T_FULL));
        steps.push_back(mk(1, 2'd0, 1, 3'b111, 3'b100, 0, 0, T_FULL));
        steps.push_back(mk(1, 2'd0, 1, 3'b111, 3'b001, 0, 0, T_DEC));
        steps.push_back(mk(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, T_DEC));
        foreach (steps[i]) begin
            applyStimulus(steps[i]);
            e = expQ.pop_front();
            checks++;
            if (outVec() !== stateVec(e)) begin
                failures++;
                $display("[TB] FAIL soft_step%0d got %b want %b", i, outVec(), stateVec(e));
            end
        end
    endtask

    task automatic test_back_to_back();
        step_t   steps[$];
        tstate_t e;
        steps.push_back(mk(1, 2'd1, 0, 3'b111, 3'b000, 0, 0, T_LFD));
        steps.push_back(mk(1, 2'd1, 0, 3'b111, 3'b000, 0, 0, T_LD));
        steps.push_back(mk(1, 2'd1, 1, 3'b111, 3'b000, 0, 0, T_FULL));
        steps.push_back(mk(1, 2'd1, 0, 3'b111, 3'b000, 0, 0, T_LAF));
        steps.push_back(mk(1, 2'd1, 0, 3'b111, 3'b000, 0, 0, T_LD));
        steps.push_back(mk(0, 2'd1, 1, 3'b111, 3'b000, 0, 0, T_FULL));
        steps.push_back(mk(0, 2'd1, 0, 3'b111, 3'b000, 1, 0, T_LAF));
        steps.push_back(mk(0, 2'd1, 0, 3'b111, 3'b000, 1, 0, T_DEC));
        steps.push_back(mk(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, T_LFD));
        steps.push_back(mk(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, T_LD));
        steps.push_back(mk(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, T_LP));
`ifdef ROUTER_FSM_PARITY_CHK_EN
        steps.push_back(mk(0, 2'd0, 1, 3'b111, 3'b000, 0, 0, T_CPE));
`endif
        steps.push_back(mk(0, 2'd0, 1, 3'b111, 3'b000, 0, 0, T_FULL));
        steps.push_back(mk(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, T_LAF));
        steps.push_back(mk(0, 2'd0, 0, 3'b111, 3'b000, 1, 0, T_DEC));
        foreach (steps[i]) begin
            applyStimulus(steps[i]);
            e = expQ.pop_front();
            checks++;
            if (outVec() !== stateVec(e)) begin
                failures++;
                $display("[TB] FAIL b2b_step%0d got %b want %b", i, outVec(), stateVec(e));
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        resetn   = 1'b0;
        test_reset();
        test_normal_packet();
        test_busy_target();
        test_invalid_address();
        test_full_stall();
        test_soft_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
